// File: rtl/traffic_pkg.sv
// Shared phase codes and light patterns for the intersection controller.
// Imported by the sequencer, its timer and the light/timer decoder.
package traffic_pkg;

   typedef enum logic [1:0] {
      S0_MAIN_G = 2'b00,
      S1_MAIN_Y = 2'b01,
      S2_SIDE_G = 2'b11,
      S3_SIDE_Y = 2'b10
   } phase_t;

   typedef enum logic {
      KIND_LONG  = 1'b0,
      KIND_SHORT = 1'b1
   } kind_t;

   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] GREEN  = 3'b001;

   // Gray-coded rotation: one bit flips per step.
   function automatic phase_t next_phase(input phase_t p);
      phase_t n;
      n = S0_MAIN_G;
      unique case (p)
         S0_MAIN_G: n = S1_MAIN_Y;
         S1_MAIN_Y: n = S2_SIDE_G;
         S2_SIDE_G: n = S3_SIDE_Y;
         S3_SIDE_Y: n = S0_MAIN_G;
      endcase
      return n;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/traffic_sequencer_phase_timer.sv
// Loadable dwell down-counter with kind tracking.
// Done pulses are registered and land in the next phase's load cycle.
module phase_timer
   import traffic_pkg::*;
#(
   parameter int LONG_CYCLES  = 30,
   parameter int SHORT_CYCLES = 5,
   parameter int CNT_W        = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic load_long,
   input  logic load_short,
   output logic expire,
   output logic LongDone,
   output logic ShortDone
);

   localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(SHORT_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   logic [CNT_W-1:0] count_q;
   kind_t            kind_q;

   assign expire = !load && (count_q == ONE);

   // Counter, kind and registered done pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         kind_q    <= KIND_LONG;
         LongDone  <= 1'b0;
         ShortDone <= 1'b0;
      end else begin
         LongDone  <= expire && (kind_q == KIND_LONG);
         ShortDone <= expire && (kind_q == KIND_SHORT);
         if (load) begin
            if (load_long) begin
               count_q <= LONG_LD;
               kind_q  <= KIND_LONG;
            end else if (load_short) begin
               count_q <= SHORT_LD;
               kind_q  <= KIND_SHORT;
            end
         end else if (expire) begin
            count_q <= '0;
         end else if (count_q > ONE) begin
            count_q <= count_q - ONE;
         end
      end
   end

endmodule

// File: rtl/traffic_sequencer.sv
// Registered phase sequencer: owns the phase code, runs dwell timers
// requested by the decoder and advances or extends on expiry.
module traffic_sequencer
   import traffic_pkg::*;
#(
   parameter int LONG_CYCLES  = 30,
   parameter int SHORT_CYCLES = 5,
   parameter int CNT_W        = 8
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       Start_LongTimer,
   input  logic       Start_ShortTimer,
   input  logic       SideRequest,
   output logic [1:0] StateOut,
   output logic       LongDone,
   output logic       ShortDone
);

   localparam int MAX_CYC = max_int(LONG_CYCLES, SHORT_CYCLES);

   if (LONG_CYCLES < 2 || SHORT_CYCLES < 2) begin : g_bad_cycles
      $fatal(1, "traffic_sequencer: dwell cycles must be >= 2");
   end
   if ((MAX_CYC - 1) > ((1 << CNT_W) - 1)) begin : g_bad_width
      $fatal(1, "traffic_sequencer: CNT_W too narrow");
   end

   phase_t state_q, state_d;
   logic   start_q, start_d;
   logic   load_req;
   logic   expire;

   assign load_req = Start_LongTimer | Start_ShortTimer;
   assign StateOut = state_q;

   phase_timer #(
      .LONG_CYCLES  (LONG_CYCLES),
      .SHORT_CYCLES (SHORT_CYCLES),
      .CNT_W        (CNT_W)
   ) u_timer (
      .clk        (Clk),
      .rst_n      (Rst_n),
      .load       (start_q),
      .load_long  (Start_LongTimer),
      .load_short (Start_ShortTimer),
      .expire     (expire),
      .LongDone   (LongDone),
      .ShortDone  (ShortDone)
   );

   // Phase and load-pending registers.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= S0_MAIN_G;
         start_q <= 1'b1;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
      end
   end

   // Leave load on a request; on expiry advance, or re-arm main-green.
   always_comb begin
      state_d = state_q;
      start_d = start_q;
      if (start_q) begin
         if (load_req) start_d = 1'b0;
      end else if (expire) begin
         start_d = 1'b1;
         if (!(state_q == S0_MAIN_G && !SideRequest))
            state_d = next_phase(state_q);
      end
   end

endmodule

// File: tb/tb_traffic_sequencer.sv
// Self-checking bench for traffic_sequencer with a dwell-based model
// and an in-loop behavioural decoder.
module tb_traffic_sequencer;

   localparam int LONG  = 4;
   localparam int SHORT = 2;

   logic       Clk = 1'b0;
   logic       Rst_n = 1'b0;
   logic       SideRequest = 1'b1;
   logic       force_both = 1'b0;
   logic       force_none = 1'b0;
   logic       Start_LongTimer;
   logic       Start_ShortTimer;
   logic [1:0] StateOut;
   logic       LongDone;
   logic       ShortDone;
   logic       cmp_en = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 Clk = ~Clk;

   // Decoder: greens ask for the long timer, yellows for the short one.
   assign Start_LongTimer = force_none ? 1'b0 : force_both ? 1'b1 :
                            (StateOut == 2'b00 || StateOut == 2'b11);
   assign Start_ShortTimer = force_none ? 1'b0 : force_both ? 1'b1 :
                             (StateOut == 2'b01 || StateOut == 2'b10);

   traffic_sequencer #(
      .LONG_CYCLES  (LONG),
      .SHORT_CYCLES (SHORT),
      .CNT_W        (4)
   ) dut (
      .Clk              (Clk),
      .Rst_n            (Rst_n),
      .Start_LongTimer  (Start_LongTimer),
      .Start_ShortTimer (Start_ShortTimer),
      .SideRequest      (SideRequest),
      .StateOut         (StateOut),
      .LongDone         (LongDone),
      .ShortDone        (ShortDone)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: tracks cycles spent in the phase against the chosen dwell.
   int m_state, m_dwell, m_age, m_ld, m_sd;
   bit m_wait, m_long;
   int order[4] = '{0, 1, 3, 2};

   always @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         m_state = 0; m_wait = 1; m_age = 0; m_dwell = 0;
         m_long = 1; m_ld = 0; m_sd = 0;
      end else begin
         m_ld = 0;
         m_sd = 0;
         if (m_wait) begin
            if (Start_LongTimer) begin
               m_dwell = LONG; m_long = 1; m_age = 1; m_wait = 0;
            end else if (Start_ShortTimer) begin
               m_dwell = SHORT; m_long = 0; m_age = 1; m_wait = 0;
            end
         end else begin
            m_age++;
            if (m_age == m_dwell) begin
               m_wait = 1;
               if (m_long) m_ld = 1; else m_sd = 1;
               if (!(m_state == 0 && !SideRequest)) begin
                  int idx = 0;
                  for (int i = 0; i < 4; i++)
                     if (order[i] == m_state) idx = i;
                  m_state = order[(idx + 1) % 4];
               end
            end
         end
      end
   end

   // Continuous comparison against the model.
   always @(negedge Clk) begin
      if (cmp_en) begin
         check("state_vs_model", int'(StateOut), m_state);
         check("longdone_vs_model", int'(LongDone), m_ld);
         check("shortdone_vs_model", int'(ShortDone), m_sd);
         check("done_exclusive", int'(LongDone & ShortDone), 0);
      end
   end

   int exp_st[13] = '{0, 0, 0, 0, 1, 1, 3, 3, 3, 3, 2, 2, 0};

   initial begin
      int k;
      // Reset held for three cycles.
      repeat (3) begin
         @(negedge Clk);
         check("reset_state", int'(StateOut), 0);
         check("reset_longdone", int'(LongDone), 0);
         check("reset_shortdone", int'(ShortDone), 0);
      end
      Rst_n = 1'b1;
      cmp_en = 1'b1;

      // Full rotation with side request present.
      for (int i = 0; i < 13; i++) begin
         if (i > 0) @(negedge Clk);
         #1;
         check($sformatf("cycle_state_%0d", i), int'(StateOut), exp_st[i]);
         check($sformatf("cycle_ld_%0d", i), int'(LongDone),
               (i == 4 || i == 10) ? 1 : 0);
         check($sformatf("cycle_sd_%0d", i), int'(ShortDone),
               (i == 6 || i == 12) ? 1 : 0);
      end

      // Main-green extension without side request.
      SideRequest = 1'b0;
      repeat (4) @(negedge Clk);
      #1;
      check("extend1_state", int'(StateOut), 0);
      check("extend1_ld", int'(LongDone), 1);
      repeat (4) @(negedge Clk);
      #1;
      check("extend2_state", int'(StateOut), 0);
      check("extend2_ld", int'(LongDone), 1);
      repeat (2) @(negedge Clk);
      SideRequest = 1'b1;
      @(negedge Clk);
      #1;
      check("extend_not_before", int'(StateOut), 0);
      @(negedge Clk);
      #1;
      check("extend_release_state", int'(StateOut), 1);
      check("extend_release_ld", int'(LongDone), 1);

      // Both requests forced in main-yellow: long wins.
      force_both = 1'b1;
      repeat (4) @(negedge Clk);
      force_both = 1'b0;
      #1;
      check("both_state", int'(StateOut), 3);
      check("both_ld", int'(LongDone), 1);
      check("both_sd", int'(ShortDone), 0);

      // No request for five edges in side-green.
      force_none = 1'b1;
      repeat (5) @(negedge Clk);
      force_none = 1'b0;
      #1;
      check("hold_state", int'(StateOut), 3);
      check("hold_ld", int'(LongDone), 0);
      check("hold_sd", int'(ShortDone), 0);
      repeat (4) @(negedge Clk);
      #1;
      check("resume_state", int'(StateOut), 2);
      check("resume_ld", int'(LongDone), 1);

      // Reset pulse mid side-green.
      k = 0;
      while (StateOut != 2'b11 && k < 30) begin
         @(negedge Clk);
         k++;
      end
      check("wait_side_green", (k < 30) ? 1 : 0, 1);
      repeat (2) @(negedge Clk);
      check("count_before_reset", int'(dut.u_timer.count_q), 2);
      #2 Rst_n = 1'b0;
      #1;
      check("midreset_state", int'(StateOut), 0);
      check("midreset_count", int'(dut.u_timer.count_q), 0);
      check("midreset_ld", int'(LongDone), 0);
      check("midreset_sd", int'(ShortDone), 0);
      #1 Rst_n = 1'b1;
      repeat (4) @(negedge Clk);
      #1;
      check("restart_state", int'(StateOut), 1);
      check("restart_ld", int'(LongDone), 1);

      repeat (2) @(negedge Clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
